// File: rtl/chain_search.sv
// Hash-bucket chain walker: follows next_ptr links through the data table RAM
// until the key matches, the chain ends, or MAX_CHAIN entries have been read.
module chain_search #(
    parameter int KEY_WIDTH   = 32,
    parameter int VALUE_WIDTH = 16,
    parameter int PTR_WIDTH   = 8,
    parameter int MAX_CHAIN   = 16,
    parameter int CNT_WIDTH   = $clog2(MAX_CHAIN + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,

    input  logic [KEY_WIDTH-1:0]   req_key_i,
    input  logic [PTR_WIDTH-1:0]   req_head_ptr_i,
    input  logic                   req_head_ptr_val_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,

    output logic [PTR_WIDTH-1:0]   ram_rd_addr_o,
    output logic                   ram_rd_en_o,
    input  logic [KEY_WIDTH-1:0]   ram_rd_key_i,
    input  logic [VALUE_WIDTH-1:0] ram_rd_value_i,
    input  logic [PTR_WIDTH-1:0]   ram_rd_next_ptr_i,
    input  logic                   ram_rd_next_ptr_val_i,

    output logic                   res_found_o,
    output logic [VALUE_WIDTH-1:0] res_value_o,
    output logic [PTR_WIDTH-1:0]   res_ptr_o,
    output logic [CNT_WIDTH-1:0]   res_depth_o,
    output logic                   res_overflow_o,
    output logic                   res_valid_o,
    input  logic                   res_ready_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        CMP  = 2'd2,
        OUT  = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] MAX_DEPTH = CNT_WIDTH'(MAX_CHAIN);

    state_t                 state_q;
    state_t                 state_d;

    logic [KEY_WIDTH-1:0]   key_q;
    logic [PTR_WIDTH-1:0]   ptr_q;
    logic [CNT_WIDTH-1:0]   depth_q;
    logic                   found_q;
    logic [VALUE_WIDTH-1:0] value_q;
    logic [PTR_WIDTH-1:0]   match_ptr_q;
    logic                   overflow_q;

    logic                   accept;
    logic                   key_hit;
    logic                   depth_at_max;

    assign accept       = (state_q == IDLE) && req_valid_i;
    assign key_hit      = (ram_rd_key_i == key_q);
    assign depth_at_max = (depth_q == MAX_DEPTH);

    // NOTE: nonblocking (<=) for every register so all state updates see the
    // pre-edge values of each other, regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output and state_d gets a default before the case, so no
    // path through the block leaves a signal unassigned and no latch appears.
    always_comb begin
        state_d     = state_q;
        req_ready_o = 1'b0;
        ram_rd_en_o = 1'b0;
        res_valid_o = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    state_d = req_head_ptr_val_i ? RD : OUT;
                end
            end
            RD: begin
                ram_rd_en_o = 1'b1;
                state_d     = CMP;
            end
            CMP: begin
                if (key_hit || !ram_rd_next_ptr_val_i || depth_at_max) begin
                    state_d = OUT;
                end else begin
                    state_d = RD;
                end
            end
            OUT: begin
                res_valid_o = 1'b1;
                if (res_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Request context: key under search, current entry pointer, entries read.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            key_q   <= '0;
            ptr_q   <= '0;
            depth_q <= '0;
        end else begin
            if (accept) begin
                key_q   <= req_key_i;
                depth_q <= '0;
                if (req_head_ptr_val_i) begin
                    ptr_q <= req_head_ptr_i;
                end
            end else if (state_q == RD) begin
                depth_q <= depth_q + CNT_WIDTH'(1);
            end else if (state_q == CMP && !key_hit && ram_rd_next_ptr_val_i
                         && !depth_at_max) begin
                ptr_q <= ram_rd_next_ptr_i;
            end
        end
    end

    // Result fields: cleared on accept, written only on the terminating compare,
    // then held untouched through OUT so backpressure sees stable values.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            found_q     <= 1'b0;
            value_q     <= '0;
            match_ptr_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            if (accept) begin
                found_q     <= 1'b0;
                value_q     <= '0;
                match_ptr_q <= '0;
                overflow_q  <= 1'b0;
            end else if (state_q == CMP) begin
                if (key_hit) begin
                    found_q     <= 1'b1;
                    value_q     <= ram_rd_value_i;
                    match_ptr_q <= ptr_q;
                end else if (ram_rd_next_ptr_val_i && depth_at_max) begin
                    overflow_q  <= 1'b1;
                end
            end
        end
    end

    assign ram_rd_addr_o  = ptr_q;

    assign res_found_o    = found_q;
    assign res_value_o    = value_q;
    assign res_ptr_o      = match_ptr_q;
    assign res_depth_o    = depth_q;
    assign res_overflow_o = overflow_q;

endmodule

// File: tb/tb_chain_search.sv
// Directed bench for chain_search: a registered-read RAM model with hand-built
// chains, cycle-exact latency checks, backpressure, and reset mid-walk.
module tb_chain_search;

    localparam int KW = 32;
    localparam int VW = 16;
    localparam int PW = 8;
    localparam int MC = 4;
    localparam int CW = $clog2(MC + 1);

    logic          clk_i = 1'b0;
    logic          rst_n_i;
    logic [KW-1:0] req_key_i;
    logic [PW-1:0] req_head_ptr_i;
    logic          req_head_ptr_val_i;
    logic          req_valid_i;
    logic          req_ready_o;
    logic [PW-1:0] ram_rd_addr_o;
    logic          ram_rd_en_o;
    logic [KW-1:0] ram_rd_key_i;
    logic [VW-1:0] ram_rd_value_i;
    logic [PW-1:0] ram_rd_next_ptr_i;
    logic          ram_rd_next_ptr_val_i;
    logic          res_found_o;
    logic [VW-1:0] res_value_o;
    logic [PW-1:0] res_ptr_o;
    logic [CW-1:0] res_depth_o;
    logic          res_overflow_o;
    logic          res_valid_o;
    logic          res_ready_i;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    chain_search #(
        .KEY_WIDTH   (KW),
        .VALUE_WIDTH (VW),
        .PTR_WIDTH   (PW),
        .MAX_CHAIN   (MC)
    ) dut (
        .clk_i                 (clk_i),
        .rst_n_i               (rst_n_i),
        .req_key_i             (req_key_i),
        .req_head_ptr_i        (req_head_ptr_i),
        .req_head_ptr_val_i    (req_head_ptr_val_i),
        .req_valid_i           (req_valid_i),
        .req_ready_o           (req_ready_o),
        .ram_rd_addr_o         (ram_rd_addr_o),
        .ram_rd_en_o           (ram_rd_en_o),
        .ram_rd_key_i          (ram_rd_key_i),
        .ram_rd_value_i        (ram_rd_value_i),
        .ram_rd_next_ptr_i     (ram_rd_next_ptr_i),
        .ram_rd_next_ptr_val_i (ram_rd_next_ptr_val_i),
        .res_found_o           (res_found_o),
        .res_value_o           (res_value_o),
        .res_ptr_o             (res_ptr_o),
        .res_depth_o           (res_depth_o),
        .res_overflow_o        (res_overflow_o),
        .res_valid_o           (res_valid_o),
        .res_ready_i           (res_ready_i)
    );

    // Data table model: one-cycle registered read, every read address logged.
    logic [KW-1:0] mem_key  [256];
    logic [VW-1:0] mem_val  [256];
    logic [PW-1:0] mem_next [256];
    logic          mem_nval [256];
    logic [PW-1:0] rd_addrs [$];

    always @(posedge clk_i) begin
        if (ram_rd_en_o) begin
            ram_rd_key_i          <= mem_key[ram_rd_addr_o];
            ram_rd_value_i        <= mem_val[ram_rd_addr_o];
            ram_rd_next_ptr_i     <= mem_next[ram_rd_addr_o];
            ram_rd_next_ptr_val_i <= mem_nval[ram_rd_addr_o];
            rd_addrs.push_back(ram_rd_addr_o);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_entry(input logic [PW-1:0] a, input logic [KW-1:0] k,
                             input logic [VW-1:0] v, input logic [PW-1:0] n,
                             input logic nv);
        mem_key[a]  = k;
        mem_val[a]  = v;
        mem_next[a] = n;
        mem_nval[a] = nv;
    endtask

    // Issues one request and returns cycles from the accept edge to res_valid_o.
    task automatic lookup(input logic [KW-1:0] key, input logic [PW-1:0] head,
                          input logic hval, output int lat);
        rd_addrs.delete();
        check("req_ready_before_req", {63'd0, req_ready_o}, 64'd1);
        req_key_i          = key;
        req_head_ptr_i     = head;
        req_head_ptr_val_i = hval;
        req_valid_i        = 1'b1;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        lat = 1;
        while (!res_valid_o && lat < 50) begin
            @(posedge clk_i); #1;
            lat++;
        end
    endtask

    task automatic check_res(input string tag, input logic found, input logic [VW-1:0] value,
                             input logic [PW-1:0] ptr, input logic [CW-1:0] depth,
                             input logic ovf);
        check({tag, "_valid"},    {63'd0, res_valid_o},    64'd1);
        check({tag, "_found"},    {63'd0, res_found_o},    {63'd0, found});
        check({tag, "_value"},    64'(res_value_o),        64'(value));
        check({tag, "_ptr"},      64'(res_ptr_o),          64'(ptr));
        check({tag, "_depth"},    64'(res_depth_o),        64'(depth));
        check({tag, "_overflow"}, {63'd0, res_overflow_o}, {63'd0, ovf});
    endtask

    task automatic release_result(input string tag);
        res_ready_i = 1'b1;
        @(posedge clk_i); #1;
        res_ready_i = 1'b0;
        check({tag, "_valid_drop"},  {63'd0, res_valid_o}, 64'd0);
        check({tag, "_ready_back"},  {63'd0, req_ready_o}, 64'd1);
    endtask

    initial begin
        int          lat;
        int          ghost;
        logic [PW-1:0] hit3_addrs [3];

        for (int i = 0; i < 256; i++) set_entry(PW'(i), 32'hFFFF_0000, 16'h0, 8'h0, 1'b0);
        set_entry(8'd5, 32'hAAAA_0001, 16'h1111, 8'd9, 1'b1);
        set_entry(8'd9, 32'hAAAA_0002, 16'h2222, 8'd2, 1'b1);
        set_entry(8'd2, 32'hCAFE_0002, 16'hBEEF, 8'd0, 1'b0);
        set_entry(8'd7, 32'h0000_7777, 16'h0707, 8'd3, 1'b1);
        set_entry(8'd3, 32'h0000_3333, 16'h0303, 8'd0, 1'b0);
        set_entry(8'd1, 32'h0000_0001, 16'h0101, 8'd1, 1'b1);
        hit3_addrs[0] = 8'd5;
        hit3_addrs[1] = 8'd9;
        hit3_addrs[2] = 8'd2;

        rst_n_i            = 1'b0;
        req_key_i          = '0;
        req_head_ptr_i     = '0;
        req_head_ptr_val_i = 1'b0;
        req_valid_i        = 1'b0;
        res_ready_i        = 1'b0;
        #1;
        check("rst_req_ready", {63'd0, req_ready_o}, 64'd1);
        check("rst_res_valid", {63'd0, res_valid_o}, 64'd0);
        check("rst_rd_en",     {63'd0, ram_rd_en_o}, 64'd0);
        check("rst_results",   {res_found_o, res_value_o, res_ptr_o, res_depth_o, res_overflow_o}, '0);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        @(posedge clk_i); #1;

        // Empty bucket: result one cycle after accept, no RAM traffic.
        lookup(32'h0000_1234, 8'd0, 1'b0, lat);
        check("empty_latency", 64'(lat), 64'd1);
        check_res("empty", 1'b0, 16'h0, 8'd0, 3'd0, 1'b0);
        check("empty_reads", 64'(rd_addrs.size()), 64'd0);
        release_result("empty");

        // Hit on third entry of 5->9->2.
        lookup(32'hCAFE_0002, 8'd5, 1'b1, lat);
        check("hit3_latency", 64'(lat), 64'd7);
        check_res("hit3", 1'b1, 16'hBEEF, 8'd2, 3'd3, 1'b0);
        check("hit3_reads", 64'(rd_addrs.size()), 64'd3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("hit3_addr%0d", i),
                  64'((i < rd_addrs.size()) ? rd_addrs[i] : 8'hFF), 64'(hit3_addrs[i]));
        end
        release_result("hit3");

        // First-entry hit.
        lookup(32'hAAAA_0001, 8'd5, 1'b1, lat);
        check("hit1_latency", 64'(lat), 64'd3);
        check_res("hit1", 1'b1, 16'h1111, 8'd5, 3'd1, 1'b0);
        release_result("hit1");

        // Miss at end of chain 7->3.
        lookup(32'h0000_DEAD, 8'd7, 1'b1, lat);
        check("miss_latency", 64'(lat), 64'd5);
        check_res("miss", 1'b0, 16'h0, 8'd0, 3'd2, 1'b0);
        release_result("miss");

        // Self-loop at entry 1 bounded by MAX_CHAIN=4.
        lookup(32'h0000_9999, 8'd1, 1'b1, lat);
        check("loop_latency", 64'(lat), 64'd9);
        check_res("loop", 1'b0, 16'h0, 8'd0, 3'd4, 1'b1);
        check("loop_reads", 64'(rd_addrs.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("loop_addr%0d", i),
                  64'((i < rd_addrs.size()) ? rd_addrs[i] : 8'hFF), 64'd1);
        end
        release_result("loop");

        // Backpressure with a second request queued behind it.
        lookup(32'h0000_7777, 8'd7, 1'b1, lat);
        check("bp_latency", 64'(lat), 64'd3);
        req_key_i          = 32'h0000_0055;
        req_head_ptr_i     = 8'd0;
        req_head_ptr_val_i = 1'b0;
        req_valid_i        = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk_i); #1;
            check($sformatf("bp_hold%0d", c),
                  {res_valid_o, req_ready_o, res_found_o, res_value_o, res_ptr_o, res_depth_o, res_overflow_o},
                  {1'b1, 1'b0, 1'b1, 16'h0707, 8'd7, 3'd1, 1'b0});
        end
        res_ready_i = 1'b1;
        @(posedge clk_i); #1;
        res_ready_i = 1'b0;
        check("b2b_first_drop",  {63'd0, res_valid_o}, 64'd0);
        check("b2b_ready_next",  {63'd0, req_ready_o}, 64'd1);
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        check_res("b2b_second", 1'b0, 16'h0, 8'd0, 3'd0, 1'b0);
        release_result("b2b_second");

        // Reset in the middle of a walk: read strobe drops at once, no result later.
        rd_addrs.delete();
        req_key_i          = 32'hCAFE_0002;
        req_head_ptr_i     = 8'd5;
        req_head_ptr_val_i = 1'b1;
        req_valid_i        = 1'b1;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        check("midrst_rd_en_before", {63'd0, ram_rd_en_o}, 64'd1);
        #2;
        rst_n_i = 1'b0;
        #1;
        check("midrst_rd_en_async", {63'd0, ram_rd_en_o}, 64'd0);
        check("midrst_req_ready",   {63'd0, req_ready_o}, 64'd1);
        check("midrst_res_valid",   {63'd0, res_valid_o}, 64'd0);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        rd_addrs.delete();
        ghost = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk_i); #1;
            if (res_valid_o) ghost++;
        end
        check("midrst_no_result", 64'(ghost), 64'd0);
        check("midrst_no_reads",  64'(rd_addrs.size()), 64'd0);
        check("midrst_idle",      {63'd0, req_ready_o}, 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
